// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types for the load/store unit: funct3 widths, memory ops, FSM states
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_e;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_DATA   = 2'd2,
    LSU_RESP   = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane extraction with sign/zero extension and sub-word store merge
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_val,
  output logic [31:0] o_store_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
    w_half = i_word[{i_addr_lo[1], 4'b0000} +: 16];
    case (i_funct3)
      F3_B:    o_load_val = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_val = {24'd0, w_byte};
      F3_H:    o_load_val = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_val = {16'd0, w_half};
      default: o_load_val = i_word;
    endcase
  end

  // Sub-word stores keep the lanes just read from RAM; SW ignores the read word.
  always_comb begin
    o_store_word = i_word;
    case (i_funct3[1:0])
      2'b00:   o_store_word[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
      2'b01:   o_store_word[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
      default: o_store_word = i_wdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit driving a word-wide registered RAM; LSU_MISALIGN_TRAP_EN traps misaligned accesses
module lsu
  import lsu_pkg::*;
#(
  parameter int RAM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output mem_op_e     mem_op,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  r_state;
  logic [31:0] r_addr_q;
  logic [31:0] r_wdata_q;
  logic [2:0]  r_funct3_q;
  logic        r_store_q;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_f3_ok;
  logic        w_misalign;
  logic        w_req_err;
  logic [31:0] w_addr_eff;
  logic [31:0] w_load_val;
  logic [31:0] w_store_word;

  always_comb begin
    case (req_funct3)
      F3_B, F3_H, F3_W: w_f3_ok = 1'b1;
      F3_BU, F3_HU:     w_f3_ok = !req_store;
      default:          w_f3_ok = 1'b0;
    endcase
    w_addr_eff = req_addr;
    w_misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (req_funct3[1:0] == 2'b01) w_misalign = req_addr[0];
    else if (req_funct3[1:0] == 2'b10) w_misalign = |req_addr[1:0];
`else
    // Without trapping, misaligned addresses fall back to natural alignment.
    if (req_funct3[1:0] == 2'b01) w_addr_eff[0] = 1'b0;
    else if (req_funct3[1:0] == 2'b10) w_addr_eff[1:0] = 2'b00;
`endif
    w_req_err = !w_f3_ok || (req_addr >= 32'(RAM_BYTES)) || w_misalign;
  end

  assign req_ready  = (r_state == LSU_IDLE) || (r_state == LSU_RESP);
  assign resp_valid = (r_state == LSU_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign mem_addr   = {r_addr_q[31:2], 2'b00};
  assign mem_wdata  = w_store_word;

  always_comb begin
    mem_op = MEM_NONE;
    if (!rst) begin
      if (r_state == LSU_ACCESS) mem_op = MEM_LOAD;
      else if (r_state == LSU_DATA && r_store_q) mem_op = MEM_STORE;
    end
  end

  lsu_align u_align (
    .i_funct3     (r_funct3_q),
    .i_addr_lo    (r_addr_q[1:0]),
    .i_word       (mem_rdata),
    .i_wdata      (r_wdata_q),
    .o_load_val   (w_load_val),
    .o_store_word (w_store_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= LSU_IDLE;
      r_addr_q   <= 32'd0;
      r_wdata_q  <= 32'd0;
      r_funct3_q <= 3'd0;
      r_store_q  <= 1'b0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        LSU_IDLE, LSU_RESP: begin
          if (req_valid) begin
            r_addr_q   <= w_addr_eff;
            r_wdata_q  <= req_wdata;
            r_funct3_q <= req_funct3;
            r_store_q  <= req_store;
            if (w_req_err) begin
              r_state <= LSU_RESP;
              r_rdata <= 32'd0;
              r_err   <= 1'b1;
            end else begin
              r_state <= LSU_ACCESS;
            end
          end else begin
            r_state <= LSU_IDLE;
          end
        end
        LSU_ACCESS: r_state <= LSU_DATA;
        default: begin
          r_state <= LSU_RESP;
          r_rdata <= r_store_q ? 32'd0 : w_load_val;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - self-checking bench for lsu: directed vectors, reset-mid-store and randomized model comparison
module tb_lsu;
  import lsu_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  mem_op_e     mem_op;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;
  int store_cnt = 0;

  logic [31:0] ram [0:1023];
  logic [7:0]  ref_mem [0:4095];

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  lsu #(.RAM_BYTES(4096)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_op     (mem_op),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered word RAM: address latched every cycle, data back next cycle.
  always @(posedge clk) begin
    if (mem_op == MEM_STORE) begin
      ram[mem_addr[11:2]] <= mem_wdata;
      store_cnt = store_cnt + 1;
    end
    mem_rdata <= ram[mem_addr[11:2]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model over a byte array: little-endian, sizes 1/2/4.
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int size;
    bit f3_ok;
    logic [31:0] ea;
    logic [63:0] v;
    f3_ok = (f3 == 0 || f3 == 1 || f3 == 2 || (!st && (f3 == 4 || f3 == 5)));
    size = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
    er = !f3_ok || (a >= 4096) || (TRAP && (a % size != 0));
    rd = 0;
    if (!er) begin
      ea = a - (a % size);
      if (st) begin
        for (int i = 0; i < size; i++) ref_mem[ea + i] = 8'(wd >> (8 * i));
      end else begin
        v = 0;
        for (int i = 0; i < size; i++) v = v | (64'(ref_mem[ea + i]) << (8 * i));
        if (f3 < 4 && size < 4 && v[8 * size - 1]) v = v | ~((64'd1 << (8 * size)) - 1);
        rd = v[31:0];
      end
    end
  endtask

  // Called at a negedge; drives the request, waits for the response pulse.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
    chk("req_ready_at_issue", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = c;
        break;
      end
    end
    rd = resp_rdata;
    er = resp_err;
  endtask

  task automatic run_checked(input string nm, input logic st, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd;
    logic er;
    int lat;
    int s0;
    s0 = store_cnt;
    do_req(st, f3, a, wd, rd, er, lat);
    chk({nm, "_latency"}, 32'(lat), exp_er ? 32'd1 : 32'd3);
    chk({nm, "_rdata"}, rd, exp_rd);
    chk({nm, "_err"}, 32'(er), 32'(exp_er));
    chk({nm, "_ram_writes"}, 32'(store_cnt - s0), (st && !exp_er) ? 32'd1 : 32'd0);
  endtask

  typedef struct {
    string       name;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] mrd;
    logic mer;
    logic st;
    logic [2:0] f3;
    logic [31:0] a, wd;
    int s0;

    vecs[0]  = '{"sw_100",   1'b1, 3'b010, 32'h100,  32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{"lw_100",   1'b0, 3'b010, 32'h100,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{"sw_init",  1'b1, 3'b010, 32'h100,  32'h11223344, 32'h0,        1'b0};
    vecs[3]  = '{"sb_101",   1'b1, 3'b000, 32'h101,  32'h000000AA, 32'h0,        1'b0};
    vecs[4]  = '{"lw_aft_sb",1'b0, 3'b010, 32'h100,  32'h0,        32'h1122AA44, 1'b0};
    vecs[5]  = '{"lb_101",   1'b0, 3'b000, 32'h101,  32'h0,        32'hFFFFFFAA, 1'b0};
    vecs[6]  = '{"lbu_101",  1'b0, 3'b100, 32'h101,  32'h0,        32'h000000AA, 1'b0};
    vecs[7]  = '{"sh_102",   1'b1, 3'b001, 32'h102,  32'h00008001, 32'h0,        1'b0};
    vecs[8]  = '{"lw_aft_sh",1'b0, 3'b010, 32'h100,  32'h0,        32'h8001AA44, 1'b0};
    vecs[9]  = '{"lh_102",   1'b0, 3'b001, 32'h102,  32'h0,        32'hFFFF8001, 1'b0};
    vecs[10] = '{"lhu_102",  1'b0, 3'b101, 32'h102,  32'h0,        32'h00008001, 1'b0};
    vecs[11] = '{"lw_102",   1'b0, 3'b010, 32'h102,  32'h0,        TRAP ? 32'h0 : 32'h8001AA44, TRAP};
    vecs[12] = '{"lw_1000",  1'b0, 3'b010, 32'h1000, 32'h0,        32'h0,        1'b1};
    vecs[13] = '{"lw_f3_011",1'b0, 3'b011, 32'h100,  32'h0,        32'h0,        1'b1};
    vecs[14] = '{"sbu_bad",  1'b1, 3'b100, 32'h100,  32'h55,       32'h0,        1'b1};
    vecs[15] = '{"lh_103",   1'b0, 3'b001, 32'h103,  32'h0,        TRAP ? 32'h0 : 32'hFFFF8001, TRAP};

    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_op", 32'(mem_op), 32'(MEM_NONE));
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors, issued back-to-back from each RESP cycle.
    for (int i = 0; i < 16; i++) begin
      run_checked(vecs[i].name, vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                  vecs[i].exp_rd, vecs[i].exp_err);
      model(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata, mrd, mer);
    end

    // Known contents for the random region and word 0x104.
    for (int w = 0; w < 64; w++) begin
      wd = $urandom;
      model(1'b1, F3_W, 32'(w * 4), wd, mrd, mer);
      run_checked("fill", 1'b1, F3_W, 32'(w * 4), wd, mrd, mer);
    end
    model(1'b1, F3_W, 32'h104, 32'h01020304, mrd, mer);
    run_checked("sw_104", 1'b1, F3_W, 32'h104, 32'h01020304, mrd, mer);

    // Reset asserted in the DATA cycle of a store must suppress the write.
    s0 = store_cnt;
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = F3_W;
    req_addr = 32'h104; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_in_data", 32'(mem_op), 32'(MEM_STORE));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_no_write", 32'(store_cnt - s0), 32'd0);
    chk("midrst_word_104", ram[65], 32'h01020304);
    run_checked("lw_104_after_rst", 1'b0, F3_W, 32'h104, 32'h0, 32'h01020304, 1'b0);

    // Randomized traffic against the byte-array model.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 11))
        0, 1:    f3 = F3_B;
        2, 3:    f3 = F3_H;
        4, 5:    f3 = F3_W;
        6, 7:    f3 = F3_BU;
        8, 9:    f3 = F3_HU;
        10:      f3 = 3'b011;
        default: f3 = 3'($urandom_range(6, 7));
      endcase
      st = 1'($urandom_range(0, 2) == 0);
      a  = ($urandom_range(0, 19) == 0) ? 32'(4096 + $urandom_range(0, 8191))
                                        : 32'($urandom_range(0, 32'h103));
      wd = $urandom;
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      model(st, f3, a, wd, mrd, mer);
      run_checked("rand", st, f3, a, wd, mrd, mer);
    end

    for (int w = 0; w < 66; w++) begin
      chk("final_ram", ram[w], {ref_mem[w * 4 + 3], ref_mem[w * 4 + 2],
                                ref_mem[w * 4 + 1], ref_mem[w * 4]});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
